// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl
//   Pointer and flag controller that runs an external dual-port RAM as a
//   synchronous FIFO. Write data goes straight to the RAM write port and read
//   data comes straight from the RAM read port. This block only produces the
//   enables, addresses, occupancy flags, the read-valid strobe and the sticky
//   error flags.
//
// Ports
//   clk           single clock, all state changes on the rising edge
//   rst_n         synchronous active-low reset
//   push          write request, accepted when the FIFO is not full
//   pop           read request, accepted when the FIFO is not empty
//   clr_err       clears overflow/underflow (a same-cycle new error wins)
//   ram_wr_en     RAM write enable (accepted push)
//   ram_wr_addr   RAM write address (low bits of the write pointer)
//   ram_rd_en     RAM read enable (accepted pop)
//   ram_rd_addr   RAM read address (low bits of the read pointer)
//   rd_valid      RAM read data is valid this cycle
//   full/empty    occupancy is DEPTH / zero
//   almost_full   occupancy >= AF_LEVEL
//   almost_empty  occupancy <= AE_LEVEL
//   count         occupancy, 0..DEPTH
//   overflow      sticky: push attempted while full
//   underflow     sticky: pop attempted while empty
// ---------------------------------------------------------------------------
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clr_err,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AF_THR  = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_THR  = AE_LEVEL[ADDR_WIDTH:0];

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the address bits are equal.
  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;
  logic                wr_acc;
  logic                rd_acc;

  // Flags come only from registered state, so push/pop cannot glitch them.
  assign full         = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                        (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
  assign empty        = (wptr == rptr);
  assign almost_full  = (count >= AF_THR);
  assign almost_empty = (count <= AE_THR);

  // Accept logic. Gating with rst_n keeps the RAM ports quiet during reset.
  // On full, a push is refused even if a pop happens in the same cycle
  // (likewise a pop on empty): there is no bypass path.
  assign wr_acc = rst_n & push & ~full;
  assign rd_acc = rst_n & pop  & ~empty;

  assign ram_wr_en   = wr_acc;
  assign ram_rd_en   = rd_acc;
  assign ram_wr_addr = wptr[ADDR_WIDTH-1:0];
  assign ram_rd_addr = rptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + ONE;
      if (rd_acc) rptr <= rptr + ONE;

      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase

      // The RAM read is registered, so its data shows up one cycle later.
      rd_valid <= rd_acc;

      // A new error in the same cycle as clr_err keeps the flag set.
      if (push && full)    overflow <= 1'b1;
      else if (clr_err)    overflow <= 1'b0;

      if (pop && empty)    underflow <= 1'b1;
      else if (clr_err)    underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl
//   Directed bench for fifo_ctrl (ADDR_WIDTH=4, DEPTH=16, AF=14, AE=2).
//   A small registered-read RAM model sits on the controller's RAM ports so
//   read data can be checked against the order in which it was written.
//   Inputs change on the falling edge; combinational outputs are sampled just
//   after that, registered outputs just after the rising edge.
// ---------------------------------------------------------------------------
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push;
  logic       pop;
  logic       clr_err;
  logic       ram_wr_en;
  logic [3:0] ram_wr_addr;
  logic       ram_rd_en;
  logic [3:0] ram_rd_addr;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic [7:0] mem [16];

  int         vectors    = 0;
  int         miscompares = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_d;
  logic [3:0] exp_waddr = 4'd0;
  logic [3:0] exp_raddr = 4'd0;

  always #5 clk = ~clk;

  fifo_ctrl #(.ADDR_WIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .pop          (pop),
    .clr_err      (clr_err),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Registered-read dual-port RAM model.
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= wr_data;
    if (ram_rd_en) rd_data <= mem[ram_rd_addr];
  end

  task automatic test_reset();
    rst_n = 1'b0; push = 1'b1; pop = 1'b1; clr_err = 1'b0; wr_data = 8'h00;
    @(posedge clk); @(posedge clk);
    @(negedge clk); #1;
    vectors++;
    if ({ram_wr_en, ram_rd_en} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_ram_en: got %b required 00", {ram_wr_en, ram_rd_en});
    end
    vectors++;
    if ({count, full, empty, almost_full, almost_empty, rd_valid, overflow, underflow}
        !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got cnt=%0d f=%b e=%b af=%b ae=%b rv=%b ov=%b un=%b required cnt=0 f=0 e=1 af=0 ae=1 rv=0 ov=0 un=0",
               count, full, empty, almost_full, almost_empty, rd_valid, overflow, underflow);
    end
    push = 1'b0; pop = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [4:0] ec;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); push = 1'b1; wr_data = 8'hA0 + 8'(i); #1;
      vectors++;
      if (ram_wr_en !== 1'b1 || ram_wr_addr !== exp_waddr) begin
        miscompares++;
        $display("[TB] FAIL fill_wr_port[%0d]: got en=%b addr=%0d required en=1 addr=%0d",
                 i, ram_wr_en, ram_wr_addr, exp_waddr);
      end
      @(posedge clk); exp_q.push_back(wr_data); exp_waddr++; #1;
      ec = 5'(i + 1);
      vectors++;
      if ({count, full, empty, almost_full, almost_empty} !==
          {ec, (i == 15), 1'b0, (ec >= 5'd14), (ec <= 5'd2)}) begin
        miscompares++;
        $display("[TB] FAIL fill_flags[%0d]: got cnt=%0d f=%b e=%b af=%b ae=%b required cnt=%0d f=%b e=0 af=%b ae=%b",
                 i, count, full, empty, almost_full, almost_empty,
                 ec, (i == 15), (ec >= 5'd14), (ec <= 5'd2));
      end
    end
    @(negedge clk); push = 1'b0;
  endtask

  task automatic test_overflow();
    @(negedge clk); push = 1'b1; wr_data = 8'hEE; #1;
    vectors++;
    if (ram_wr_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ovf_wr_en: got %b required 0", ram_wr_en);
    end
    @(posedge clk); #1;
    vectors++;
    if ({count, full, overflow} !== {5'd16, 1'b1, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL ovf_set: got cnt=%0d f=%b ov=%b required cnt=16 f=1 ov=1", count, full, overflow);
    end
    @(negedge clk); push = 1'b1; clr_err = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_err_wins: got %b required 1", overflow);
    end
    @(negedge clk); push = 1'b0; clr_err = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (overflow !== 1'b0 || count !== 5'd16) begin
      miscompares++;
      $display("[TB] FAIL ovf_clear: got ov=%b cnt=%0d required ov=0 cnt=16", overflow, count);
    end
    @(negedge clk); clr_err = 1'b0;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); pop = 1'b1; #1;
      vectors++;
      if (ram_rd_en !== 1'b1 || ram_rd_addr !== exp_raddr) begin
        miscompares++;
        $display("[TB] FAIL drain_rd_port[%0d]: got en=%b addr=%0d required en=1 addr=%0d",
                 i, ram_rd_en, ram_rd_addr, exp_raddr);
      end
      @(posedge clk); exp_raddr++; exp_d = exp_q.pop_front(); #1;
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== exp_d ||
          {count, full, empty} !== {5'(15 - i), 1'b0, (i == 15)}) begin
        miscompares++;
        $display("[TB] FAIL drain_data[%0d]: got rv=%b d=%h cnt=%0d f=%b e=%b required rv=1 d=%h cnt=%0d f=0 e=%b",
                 i, rd_valid, rd_data, count, full, empty, exp_d, 15 - i, (i == 15));
      end
    end
    @(negedge clk); pop = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL drain_rv_drop: got %b required 0", rd_valid);
    end
  endtask

  task automatic test_underflow();
    @(negedge clk); pop = 1'b1; #1;
    vectors++;
    if (ram_rd_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL unf_rd_en: got %b required 0", ram_rd_en);
    end
    @(posedge clk); #1;
    vectors++;
    if ({rd_valid, underflow, count, empty} !== {1'b0, 1'b1, 5'd0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL unf_set: got rv=%b un=%b cnt=%0d e=%b required rv=0 un=1 cnt=0 e=1",
               rd_valid, underflow, count, empty);
    end
    @(negedge clk); pop = 1'b0; clr_err = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (underflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL unf_clear: got %b required 0", underflow);
    end
    @(negedge clk); clr_err = 1'b0; push = 1'b1; pop = 1'b1; wr_data = 8'h5A; #1;
    vectors++;
    if ({ram_wr_en, ram_rd_en} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL empty_pushpop_en: got %b required 10", {ram_wr_en, ram_rd_en});
    end
    @(posedge clk); exp_q.push_back(wr_data); exp_waddr++; #1;
    vectors++;
    if ({count, underflow, rd_valid, empty} !== {5'd1, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL empty_pushpop: got cnt=%0d un=%b rv=%b e=%b required cnt=1 un=1 rv=0 e=0",
               count, underflow, rd_valid, empty);
    end
    @(negedge clk); push = 1'b0; pop = 1'b1;
    @(posedge clk); exp_raddr++; exp_d = exp_q.pop_front(); #1;
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== exp_d || count !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL unf_readback: got rv=%b d=%h cnt=%0d required rv=1 d=%h cnt=0",
               rd_valid, rd_data, count, exp_d);
    end
    @(negedge clk); pop = 1'b0; clr_err = 1'b1;
    @(posedge clk);
    @(negedge clk); clr_err = 1'b0;
  endtask

  task automatic test_steady();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); push = 1'b1; wr_data = 8'h10 + 8'(i);
      @(posedge clk); exp_q.push_back(wr_data); exp_waddr++;
    end
    #1;
    vectors++;
    if (count !== 5'd5) begin
      miscompares++;
      $display("[TB] FAIL steady_prefill: got cnt=%0d required 5", count);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); push = 1'b1; pop = 1'b1; wr_data = 8'h40 + 8'(i); #1;
      vectors++;
      if ({ram_wr_en, ram_rd_en} !== 2'b11 || ram_wr_addr !== exp_waddr || ram_rd_addr !== exp_raddr) begin
        miscompares++;
        $display("[TB] FAIL steady_ports[%0d]: got en=%b wa=%0d ra=%0d required en=11 wa=%0d ra=%0d",
                 i, {ram_wr_en, ram_rd_en}, ram_wr_addr, ram_rd_addr, exp_waddr, exp_raddr);
      end
      @(posedge clk);
      exp_q.push_back(wr_data); exp_d = exp_q.pop_front(); exp_waddr++; exp_raddr++; #1;
      vectors++;
      if (count !== 5'd5 || rd_valid !== 1'b1 || rd_data !== exp_d) begin
        miscompares++;
        $display("[TB] FAIL steady_data[%0d]: got cnt=%0d rv=%b d=%h required cnt=5 rv=1 d=%h",
                 i, count, rd_valid, rd_data, exp_d);
      end
    end
    @(negedge clk); pop = 1'b0; push = 1'b0;
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); push = 1'b1; wr_data = 8'hC0 + 8'(i);
      @(posedge clk); exp_q.push_back(wr_data); exp_waddr++;
    end
    #1;
    vectors++;
    if (count !== 5'd16 || full !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL refill: got cnt=%0d f=%b required cnt=16 f=1", count, full);
    end
    @(negedge clk); push = 1'b1; pop = 1'b1; wr_data = 8'hFF; #1;
    vectors++;
    if ({ram_wr_en, ram_rd_en} !== 2'b01 || ram_rd_addr !== exp_raddr) begin
      miscompares++;
      $display("[TB] FAIL full_pushpop_en: got en=%b ra=%0d required en=01 ra=%0d",
               {ram_wr_en, ram_rd_en}, ram_rd_addr, exp_raddr);
    end
    @(posedge clk); exp_raddr++; exp_d = exp_q.pop_front(); #1;
    vectors++;
    if ({count, overflow, full} !== {5'd15, 1'b1, 1'b0} || rd_valid !== 1'b1 || rd_data !== exp_d) begin
      miscompares++;
      $display("[TB] FAIL full_pushpop: got cnt=%0d ov=%b f=%b rv=%b d=%h required cnt=15 ov=1 f=0 rv=1 d=%h",
               count, overflow, full, rd_valid, rd_data, exp_d);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); push = 1'b0; pop = 1'b1;
      @(posedge clk); exp_raddr++; exp_d = exp_q.pop_front(); #1;
      vectors++;
      if (rd_data !== exp_d || count !== 5'(14 - i)) begin
        miscompares++;
        $display("[TB] FAIL partial_drain[%0d]: got d=%h cnt=%0d required d=%h cnt=%0d",
                 i, rd_data, count, exp_d, 14 - i);
      end
    end
    @(negedge clk); pop = 1'b0;
  endtask

  task automatic test_mid_reset();
    @(negedge clk); rst_n = 1'b0; pop = 1'b1; #1;
    vectors++;
    if (ram_rd_en !== 1'b0 || count !== 5'd9) begin
      miscompares++;
      $display("[TB] FAIL midrst_rd_en: got en=%b cnt=%0d required en=0 cnt=9", ram_rd_en, count);
    end
    @(posedge clk); #1;
    vectors++;
    if ({count, full, empty, almost_full, almost_empty, rd_valid, overflow, underflow}
        !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL midrst_state: got cnt=%0d f=%b e=%b af=%b ae=%b rv=%b ov=%b un=%b required cnt=0 f=0 e=1 af=0 ae=1 rv=0 ov=0 un=0",
               count, full, empty, almost_full, almost_empty, rd_valid, overflow, underflow);
    end
    exp_q.delete(); exp_waddr = 4'd0; exp_raddr = 4'd0;
    @(negedge clk); rst_n = 1'b1; pop = 1'b0; push = 1'b1; wr_data = 8'h77; #1;
    vectors++;
    if (ram_wr_en !== 1'b1 || ram_wr_addr !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL midrst_wptr: got en=%b wa=%0d required en=1 wa=0", ram_wr_en, ram_wr_addr);
    end
    @(posedge clk); exp_q.push_back(wr_data); exp_waddr++;
    @(negedge clk); push = 1'b0; pop = 1'b1; #1;
    vectors++;
    if (ram_rd_addr !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL midrst_rptr: got ra=%0d required 0", ram_rd_addr);
    end
    @(posedge clk); exp_d = exp_q.pop_front(); #1;
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== exp_d || empty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrst_readback: got rv=%b d=%h e=%b required rv=1 d=%h e=1",
               rd_valid, rd_data, empty, exp_d);
    end
    @(negedge clk); pop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_steady();
    test_full_push_pop();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
